// File: rtl/gol_pkg.sv
// Shared Game-of-Life geometry and the grid loader's state encoding.
package gol_pkg;

  localparam int X_SIZE        = 1280;
  localparam int Y_SIZE        = 720;
  localparam int WORD_W        = 32;
  localparam int X_WIDTH       = $clog2(X_SIZE);
  localparam int Y_WIDTH       = $clog2(Y_SIZE);
  localparam int WORDS_PER_ROW = X_SIZE / WORD_W;
  localparam int WC_WIDTH      = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    WRITE   = 2'b10,
    DONE    = 2'b11
  } loader_state_t;

endpackage

// File: rtl/row_assembler.sv
// Shifts incoming words MSB-first into a full-row register and counts them;
// row_full pulses on the accept that completes the row.
module row_assembler
  import gol_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              clear,
  input  logic              accept,
  input  logic [WORD_W-1:0] word_data,
  output logic [X_SIZE-1:0] row_data,
  output logic              row_full
);

  localparam logic [WC_WIDTH-1:0] LAST_WORD = WC_WIDTH'(WORDS_PER_ROW - 1);

  logic [WC_WIDTH-1:0] word_cnt_reg;
  logic [X_SIZE-1:0]   row_sr_reg;

  // clear only rewinds the counter; stale row bits are fully overwritten by the next row
  always_ff @(posedge clk) begin
    if (srst) begin
      word_cnt_reg <= '0;
      row_sr_reg   <= '0;
    end else if (clear) begin
      word_cnt_reg <= '0;
    end else if (accept) begin
      row_sr_reg   <= {row_sr_reg[X_SIZE-WORD_W-1:0], word_data};
      word_cnt_reg <= (word_cnt_reg == LAST_WORD) ? '0 : word_cnt_reg + 1'b1;
    end
  end

  assign row_full = accept && !clear && (word_cnt_reg == LAST_WORD);
  assign row_data = row_sr_reg;

endmodule

// File: rtl/grid_loader.sv
// Streams the initial grid into the frame BRAM one assembled row at a time,
// then raises a sticky init_done.
module grid_loader
  import gol_pkg::*;
(
  input  logic               out_stream_aclk,
  input  logic               periph_reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic               wr_grant,
  output logic [Y_WIDTH-1:0] bram_addr,
  output logic [X_SIZE-1:0]  bram_din,
  output logic               bram_we,
  output logic               busy,
  output logic               init_done,
  output logic [Y_WIDTH-1:0] row_count
);

  localparam logic [Y_WIDTH-1:0] LAST_ROW = Y_WIDTH'(Y_SIZE - 1);

  loader_state_t      state_reg, state_next;
  logic [Y_WIDTH-1:0] row_reg, row_next;
  logic               clear;
  logic               accept;
  logic               row_full;
  logic [X_SIZE-1:0]  row_data;

  // Handshake and strobe are kept outside the FSM block so row_full never feeds back into them
  assign word_ready = (state_reg == COLLECT) && !abort;
  assign bram_we    = (state_reg == WRITE) && wr_grant && !abort;
  assign accept     = word_valid && word_ready;

  row_assembler u_row_assembler (
    .clk       (out_stream_aclk),
    .srst      (periph_reset),
    .clear     (clear),
    .accept    (accept),
    .word_data (word_data),
    .row_data  (row_data),
    .row_full  (row_full)
  );

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state_reg <= IDLE;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    clear      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = COLLECT;
          row_next   = '0;
          clear      = 1'b1;
        end
      end
      COLLECT: begin
        if (row_full) state_next = WRITE;
      end
      WRITE: begin
        if (wr_grant) begin
          // The last row leaves the counter at Y_SIZE-1 so the address never wraps
          if (row_reg == LAST_ROW) begin
            state_next = DONE;
          end else begin
            row_next   = row_reg + 1'b1;
            state_next = COLLECT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      row_next   = '0;
      clear      = 1'b1;
    end
  end

  assign bram_addr = row_reg;
  assign bram_din  = row_data;
  assign row_count = row_reg;
  assign busy      = (state_reg == COLLECT) || (state_reg == WRITE);
  assign init_done = (state_reg == DONE);

endmodule
